// File: rtl/dcache_victim_wb_ctrl.sv
// Victim/store write buffer between the data cache and the bridge write port.
// In-order FIFO of evictions/uncached stores with read-after-write line conflict detection.
module dcache_victim_wb_ctrl #(
  parameter int LINE_WIDTH   = 128,
  parameter int OFFSET_WIDTH = 4,
  parameter int DEPTH        = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_req,
  input  logic [2:0]            wb_type,
  input  logic [31:0]           wb_addr,
  input  logic [3:0]            wb_wstrb,
  input  logic [LINE_WIDTH-1:0] wb_data,
  output logic                  wb_rdy,
  input  logic [31:0]           rd_chk_addr,
  output logic                  rd_conflict,
  output logic                  data_wr_req,
  output logic [2:0]            data_wr_type,
  output logic [31:0]           data_wr_addr,
  output logic [3:0]            data_wr_wstrb,
  output logic [LINE_WIDTH-1:0] data_wr_data,
  input  logic                  data_wr_rdy,
  input  logic                  bridge_wr_empty,
  output logic                  wb_all_empty
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int LINE_W = 32 - OFFSET_WIDTH;

  typedef enum logic {IF_IDLE, IF_BUSY} if_state_t;

  typedef struct packed {
    logic [2:0]            typ;
    logic [31:0]           addr;
    logic [3:0]            wstrb;
    logic [LINE_WIDTH-1:0] data;
  } entry_t;

  entry_t            mem [DEPTH];
  logic [PTR_W-1:0]  head_ptr, tail_ptr;
  logic [PTR_W:0]    count;
  logic              push, pop;
  entry_t            head;
  if_state_t         if_state, if_state_nxt;
  logic [LINE_W-1:0] inflight_line;
  logic [LINE_W-1:0] rd_line;
  logic [PTR_W-1:0]  slot_off;

  assign wb_rdy      = (count != (PTR_W+1)'(DEPTH));
  assign data_wr_req = (count != '0);
  assign push        = wb_req && wb_rdy;
  assign pop         = data_wr_req && data_wr_rdy;

  assign head          = mem[head_ptr];
  assign data_wr_type  = head.typ;
  assign data_wr_addr  = head.addr;
  assign data_wr_wstrb = head.wstrb;
  assign data_wr_data  = head.data;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_ptr <= '0;
      tail_ptr <= '0;
      count    <= '0;
    end else begin
      if (push) tail_ptr <= tail_ptr + 1'b1;
      if (pop)  head_ptr <= head_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: payload storage has no reset; validity comes solely from count and the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[tail_ptr] <= '{typ: wb_type, addr: wb_addr, wstrb: wb_wstrb, data: wb_data};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_state      <= IF_IDLE;
      inflight_line <= '0;
    end else begin
      if_state <= if_state_nxt;
      if (pop) inflight_line <= head.addr[31:OFFSET_WIDTH];
    end
  end

  // NOTE: combinational outputs get a default first so no path can infer a latch.
  always_comb begin
    if_state_nxt = if_state;
    if (pop)
      if_state_nxt = IF_BUSY;
    else if (if_state == IF_BUSY && bridge_wr_empty)
      if_state_nxt = IF_IDLE;
  end

  assign rd_line = rd_chk_addr[31:OFFSET_WIDTH];

  // An entry is live when its distance from head is below count.
  always_comb begin
    rd_conflict = (if_state == IF_BUSY) && (inflight_line == rd_line);
    slot_off    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot_off = PTR_W'(i) - head_ptr;
      if (({1'b0, slot_off} < count) && (mem[i].addr[31:OFFSET_WIDTH] == rd_line))
        rd_conflict = 1'b1;
    end
  end

  assign wb_all_empty = (count == '0) && (if_state == IF_IDLE) && bridge_wr_empty;

endmodule

// File: tb/tb_dcache_victim_wb_ctrl.sv
// Self-checking bench for dcache_victim_wb_ctrl: vector table, directed corner
// sequences and random traffic against a queue-based reference model.
module tb_dcache_victim_wb_ctrl;

  localparam int LW    = 128;
  localparam int OW    = 4;
  localparam int DEPTH = 2;

  logic          clk, reset;
  logic          wb_req;
  logic [2:0]    wb_type;
  logic [31:0]   wb_addr;
  logic [3:0]    wb_wstrb;
  logic [LW-1:0] wb_data;
  logic          wb_rdy;
  logic [31:0]   rd_chk_addr;
  logic          rd_conflict;
  logic          data_wr_req;
  logic [2:0]    data_wr_type;
  logic [31:0]   data_wr_addr;
  logic [3:0]    data_wr_wstrb;
  logic [LW-1:0] data_wr_data;
  logic          data_wr_rdy;
  logic          bridge_wr_empty;
  logic          wb_all_empty;

  dcache_victim_wb_ctrl #(.LINE_WIDTH(LW), .OFFSET_WIDTH(OW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wb_req(wb_req), .wb_type(wb_type), .wb_addr(wb_addr), .wb_wstrb(wb_wstrb),
    .wb_data(wb_data), .wb_rdy(wb_rdy),
    .rd_chk_addr(rd_chk_addr), .rd_conflict(rd_conflict),
    .data_wr_req(data_wr_req), .data_wr_type(data_wr_type), .data_wr_addr(data_wr_addr),
    .data_wr_wstrb(data_wr_wstrb), .data_wr_data(data_wr_data), .data_wr_rdy(data_wr_rdy),
    .bridge_wr_empty(bridge_wr_empty), .wb_all_empty(wb_all_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    typ;
    logic [31:0]   addr;
    logic [3:0]    wstrb;
    logic [LW-1:0] data;
  } ent_t;

  typedef struct {
    logic        req;
    logic [2:0]  typ;
    logic [31:0] addr;
    logic        rdy;
    logic        be;
    logic [31:0] chk;
    logic        e_wb_rdy;
    logic        e_req;
    logic        e_conf;
    logic        e_ae;
    logic [31:0] e_addr;
    logic [2:0]  e_typ;
  } vec_t;

  // Reference model: pending writes as a queue, plus the last line handed to the bridge.
  ent_t            mq[$];
  bit              m_busy;
  logic [31-OW:0]  m_line;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic req, input logic [2:0] typ, input logic [31:0] addr,
                       input logic rdy, input logic be, input logic [31:0] chk);
    wb_req          = req;
    wb_type         = typ;
    wb_addr         = addr;
    wb_wstrb        = (typ == 3'b100) ? 4'hF : 4'(addr[3:0] | 4'h1);
    wb_data         = {addr ^ 32'hA5A5_0000, ~addr, addr + 32'd7, addr};
    data_wr_rdy     = rdy;
    bridge_wr_empty = be;
    rd_chk_addr     = chk;
  endtask

  function automatic bit m_conflict();
    bit c = m_busy && (m_line == rd_chk_addr[31:OW]);
    foreach (mq[i]) if (mq[i].addr[31:OW] == rd_chk_addr[31:OW]) c = 1'b1;
    return c;
  endfunction

  task automatic check_model(input string tag);
    check({tag, "/wb_rdy"},       LW'(wb_rdy),       LW'(mq.size() < DEPTH));
    check({tag, "/data_wr_req"},  LW'(data_wr_req),  LW'(mq.size() != 0));
    if (mq.size() != 0) begin
      check({tag, "/data_wr_type"},  LW'(data_wr_type),  LW'(mq[0].typ));
      check({tag, "/data_wr_addr"},  LW'(data_wr_addr),  LW'(mq[0].addr));
      check({tag, "/data_wr_wstrb"}, LW'(data_wr_wstrb), LW'(mq[0].wstrb));
      check({tag, "/data_wr_data"},  data_wr_data,       mq[0].data);
    end
    check({tag, "/rd_conflict"},  LW'(rd_conflict),  LW'(m_conflict()));
    check({tag, "/wb_all_empty"}, LW'(wb_all_empty),
          LW'(mq.size() == 0 && !m_busy && bridge_wr_empty));
  endtask

  // Inputs are already applied after a falling edge; compare, cross a rising edge, update model.
  task automatic cycle(input string tag);
    bit   acc, popd;
    ent_t e;
    #1;
    check_model(tag);
    acc  = wb_req && (mq.size() < DEPTH);
    popd = data_wr_rdy && (mq.size() != 0);
    @(posedge clk);
    if (popd) begin
      e      = mq.pop_front();
      m_busy = 1'b1;
      m_line = e.addr[31:OW];
    end else if (m_busy && bridge_wr_empty) begin
      m_busy = 1'b0;
    end
    if (acc) mq.push_back('{typ: wb_type, addr: wb_addr, wstrb: wb_wstrb, data: wb_data});
    if (mq.size() > DEPTH) begin
      n_checks++;
      n_errors++;
      $display("FAIL model_depth: got %0d entries, limit %0d", mq.size(), DEPTH);
    end
    @(negedge clk);
  endtask

  task automatic model_reset();
    mq.delete();
    m_busy = 1'b0;
    m_line = '0;
  endtask

  vec_t vt[8];

  initial begin
    model_reset();
    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b1, 32'h0);
    reset = 1'b1;
    #3;
    check("rst/wb_rdy", LW'(wb_rdy), LW'(1));
    check("rst/data_wr_req", LW'(data_wr_req), LW'(0));
    check("rst/rd_conflict", LW'(rd_conflict), LW'(0));
    check("rst/wb_all_empty_hi", LW'(wb_all_empty), LW'(1));
    bridge_wr_empty = 1'b0;
    #1;
    check("rst/wb_all_empty_lo", LW'(wb_all_empty), LW'(0));
    bridge_wr_empty = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Line then word push with the bridge stalled, then ordered drain and tracker release.
    vt[0] = '{1'b1, 3'b100, 32'h1C00_0040, 1'b0, 1'b1, 32'h1C00_004C, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 3'b000};
    vt[1] = '{1'b1, 3'b010, 32'h1FE0_01E0, 1'b0, 1'b1, 32'h1C00_004C, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1C00_0040, 3'b100};
    vt[2] = '{1'b0, 3'b000, 32'h0,         1'b0, 1'b1, 32'h1C00_004C, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1C00_0040, 3'b100};
    vt[3] = '{1'b0, 3'b000, 32'h0,         1'b1, 1'b1, 32'h1C00_004C, 1'b0, 1'b1, 1'b1, 1'b0, 32'h1C00_0040, 3'b100};
    vt[4] = '{1'b0, 3'b000, 32'h0,         1'b1, 1'b0, 32'h1C00_004C, 1'b1, 1'b1, 1'b1, 1'b0, 32'h1FE0_01E0, 3'b010};
    vt[5] = '{1'b0, 3'b000, 32'h0,         1'b0, 1'b0, 32'h1C00_004C, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000};
    vt[6] = '{1'b0, 3'b000, 32'h0,         1'b0, 1'b1, 32'h1FE0_01E4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 3'b000};
    vt[7] = '{1'b0, 3'b000, 32'h0,         1'b0, 1'b1, 32'h1FE0_01E4, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 3'b000};
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].req, vt[i].typ, vt[i].addr, vt[i].rdy, vt[i].be, vt[i].chk);
      #1;
      check($sformatf("tbl%0d/wb_rdy", i), LW'(wb_rdy), LW'(vt[i].e_wb_rdy));
      check($sformatf("tbl%0d/data_wr_req", i), LW'(data_wr_req), LW'(vt[i].e_req));
      check($sformatf("tbl%0d/rd_conflict", i), LW'(rd_conflict), LW'(vt[i].e_conf));
      check($sformatf("tbl%0d/wb_all_empty", i), LW'(wb_all_empty), LW'(vt[i].e_ae));
      if (vt[i].e_req) begin
        check($sformatf("tbl%0d/addr", i), LW'(data_wr_addr), LW'(vt[i].e_addr));
        check($sformatf("tbl%0d/type", i), LW'(data_wr_type), LW'(vt[i].e_typ));
      end
      cycle($sformatf("tbl%0d", i));
    end

    // Asynchronous reset while two entries are queued and one is in flight.
    drive(1'b1, 3'b100, 32'h2000_0100, 1'b0, 1'b0, 32'h2000_0200); cycle("mid/a");
    drive(1'b1, 3'b100, 32'h2000_0200, 1'b0, 1'b0, 32'h2000_0200); cycle("mid/b");
    drive(1'b0, 3'b000, 32'h0,         1'b1, 1'b0, 32'h2000_0200); cycle("mid/pop");
    drive(1'b1, 3'b001, 32'h2000_0302, 1'b0, 1'b0, 32'h2000_0200); cycle("mid/c");
    drive(1'b0, 3'b000, 32'h0,         1'b0, 1'b0, 32'h2000_0200);
    #1;
    check("mid/pre_conflict", LW'(rd_conflict), LW'(1));
    check("mid/pre_wb_rdy", LW'(wb_rdy), LW'(0));
    #1;
    reset = 1'b1;
    #1;
    check("mid/data_wr_req", LW'(data_wr_req), LW'(0));
    check("mid/wb_rdy", LW'(wb_rdy), LW'(1));
    check("mid/rd_conflict", LW'(rd_conflict), LW'(0));
    check("mid/wb_all_empty", LW'(wb_all_empty), LW'(0));
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    bridge_wr_empty = 1'b1;
    cycle("mid/after");

    // Full FIFO: a push coinciding with a pop is rejected, then accepted next cycle.
    drive(1'b1, 3'b010, 32'h3000_0010, 1'b0, 1'b1, 32'h0); cycle("full/d");
    drive(1'b1, 3'b010, 32'h3000_0020, 1'b0, 1'b1, 32'h0); cycle("full/e");
    drive(1'b1, 3'b010, 32'h3000_0030, 1'b1, 1'b1, 32'h0);
    #1;
    check("full/reject_wb_rdy", LW'(wb_rdy), LW'(0));
    cycle("full/pushpop");
    drive(1'b1, 3'b010, 32'h3000_0030, 1'b0, 1'b1, 32'h0);
    #1;
    check("full/retry_wb_rdy", LW'(wb_rdy), LW'(1));
    check("full/head_after_pop", LW'(data_wr_addr), LW'(32'h3000_0020));
    cycle("full/retry");
    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b1, 32'h0);
    #1;
    check("full/refilled_wb_rdy", LW'(wb_rdy), LW'(0));
    cycle("full/hold");
    drive(1'b0, 3'b000, 32'h0, 1'b1, 1'b1, 32'h0); cycle("full/drain0");
    check("full/last_head", LW'(data_wr_addr), LW'(32'h3000_0030));
    cycle("full/drain1");
    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b1, 32'h0); cycle("full/idle");

    // Line conflict held through pop until the bridge empties; neighbouring line never conflicts.
    for (int p = 0; p < 2; p++) begin
      logic [31:0] chk;
      logic        hit;
      chk = (p == 0) ? 32'h1C00_004C : 32'h1C00_0050;
      hit = (p == 0);
      drive(1'b1, 3'b100, 32'h1C00_0040, 1'b0, 1'b0, chk); cycle("raw/push");
      drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, chk);
      #1; check($sformatf("raw%0d/queued", p), LW'(rd_conflict), LW'(hit));
      cycle("raw/queued");
      drive(1'b0, 3'b000, 32'h0, 1'b1, 1'b0, chk);
      #1; check($sformatf("raw%0d/popcyc", p), LW'(rd_conflict), LW'(hit));
      cycle("raw/pop");
      for (int k = 0; k < 2; k++) begin
        drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, chk);
        #1; check($sformatf("raw%0d/flight%0d", p, k), LW'(rd_conflict), LW'(hit));
        cycle("raw/flight");
      end
      drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b1, chk);
      #1; check($sformatf("raw%0d/empty_edge", p), LW'(rd_conflict), LW'(hit));
      cycle("raw/empty_edge");
      #1; check($sformatf("raw%0d/released", p), LW'(rd_conflict), LW'(0));
      check($sformatf("raw%0d/all_empty", p), LW'(wb_all_empty), LW'(1));
      cycle("raw/released");
    end

    // Global-empty waits for the bridge and for the tracker to return to idle.
    drive(1'b1, 3'b010, 32'h4000_0008, 1'b0, 1'b1, 32'h0);
    #1; check("ae/before", LW'(wb_all_empty), LW'(1));
    cycle("ae/push");
    drive(1'b0, 3'b000, 32'h0, 1'b1, 1'b1, 32'h0);
    #1; check("ae/queued", LW'(wb_all_empty), LW'(0));
    cycle("ae/pop");
    for (int k = 0; k < 5; k++) begin
      drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b0, 32'h0);
      #1; check($sformatf("ae/bridge_busy%0d", k), LW'(wb_all_empty), LW'(0));
      cycle("ae/busy");
    end
    drive(1'b0, 3'b000, 32'h0, 1'b0, 1'b1, 32'h0);
    #1; check("ae/bridge_rise", LW'(wb_all_empty), LW'(0));
    cycle("ae/rise");
    #1; check("ae/settled", LW'(wb_all_empty), LW'(1));
    cycle("ae/settled");

    // Random traffic over a handful of lines so conflicts and full/empty boundaries recur.
    for (int n = 0; n < 10000; n++) begin
      logic [2:0]  typ;
      logic [31:0] addr;
      logic [31:0] chk;
      typ  = ($urandom_range(0, 3) == 3) ? 3'b100 : 3'($urandom_range(0, 2));
      addr = 32'h1C00_0000 | (32'($urandom_range(0, 5)) << OW) | 32'($urandom_range(0, 15));
      chk  = 32'h1C00_0000 | (32'($urandom_range(0, 6)) << OW) | 32'($urandom_range(0, 15));
      drive(1'($urandom_range(0, 1)), typ, addr, 1'($urandom_range(0, 2) != 0),
            1'($urandom_range(0, 3) != 0), chk);
      cycle("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
